// File: rtl/cpu_pkg.sv
// Shared CPU definitions: LSU op encodings, LSU FSM states and the latched access context.
package cpu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} lsu_state_t;

  // Only what the load-extension path needs after the bus request is out.
  typedef struct packed {
    logic       we;
    logic [2:0] op;
    logic [1:0] lo;
  } lsu_ctx_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one access: store strobes/shift, load extraction/extension,
// and the misaligned/illegal-op flag.
module lsu_lane_align
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  logic [31:0] lane;

  always_comb begin
    wstrb     = 4'b0000;
    rdata_ext = '0;
    bad       = 1'b0;
    wdata_sh  = wdata << {addr_lo, 3'b000};
    lane      = rdata >> {addr_lo, 3'b000};
    case (op)
      LSU_B: begin
        wstrb     = 4'b0001 << addr_lo;
        rdata_ext = {{24{lane[7]}}, lane[7:0]};
      end
      LSU_BU: begin
        wstrb     = 4'b0001 << addr_lo;
        rdata_ext = {24'h0, lane[7:0]};
      end
      LSU_H: begin
        wstrb     = 4'b0011 << addr_lo;
        bad       = addr_lo[0];
        rdata_ext = {{16{lane[15]}}, lane[15:0]};
      end
      LSU_HU: begin
        wstrb     = 4'b0011 << addr_lo;
        bad       = addr_lo[0];
        rdata_ext = {16'h0, lane[15:0]};
      end
      LSU_W: begin
        wstrb     = 4'b1111;
        bad       = |addr_lo;
        rdata_ext = lane;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one access per handshake from execute, one outstanding bus request,
// registered bus and writeback outputs, optional response timeout.
module lsu_mem_master
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t  state;
  lsu_ctx_t    ctx;
  logic [CW-1:0] cnt;

  logic [2:0]  al_op;
  logic [1:0]  al_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_bad;

  assign req_ready = (state == IDLE);

  // In IDLE the aligner checks the incoming request; afterwards it extends the returned word.
  assign al_op = req_ready ? req_op        : ctx.op;
  assign al_lo = req_ready ? req_addr[1:0] : ctx.lo;

  lsu_lane_align u_align (
    .op        (al_op),
    .addr_lo   (al_lo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .wstrb     (al_wstrb),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata),
    .bad       (al_bad)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ctx           <= '0;
      cnt           <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wstrb     <= 4'b0000;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          ctx <= '{we: req_we, op: req_op, lo: req_addr[1:0]};
          if (al_bad) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_addr      <= {req_addr[31:2], 2'b00};
            mem_wen       <= req_we;
            mem_wdata     <= req_we ? al_wdata : '0;
            mem_wstrb     <= req_we ? al_wstrb : 4'b0000;
          end
        end
        REQ: if (mem_req_ready) begin
          state         <= WAIT;
          mem_req_valid <= 1'b0;
          cnt           <= '0;
        end
        // A response in the final timeout cycle takes priority over the timeout.
        WAIT: if (mem_resp_valid) begin
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ctx.we ? '0 : al_rdata;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        RSP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: scoreboard of expected responses, immediate-assert checks.
module tb_lsu_mem_master;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a falling edge; the accept happens on the rising edge between.
  task automatic do_req(input string tag, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    chk({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic mem_accept(input string tag, input logic [31:0] a, input logic wen,
                            input logic [3:0] strb, input logic chk_wd, input logic [31:0] wd);
    chk({tag, " mem_req_valid"}, mem_req_valid, 1);
    chk({tag, " mem_addr"}, mem_addr, a);
    chk({tag, " mem_wen"}, mem_wen, wen);
    chk({tag, " mem_wstrb"}, mem_wstrb, strb);
    if (chk_wd) chk({tag, " mem_wdata"}, mem_wdata, wd);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk({tag, " mem_req_valid drop"}, mem_req_valid, 0);
  endtask

  task automatic mem_resp(input logic [31:0] rd);
    mem_resp_valid = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic take_rsp(input string tag);
    exp_t e;
    int   n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      chk({tag, " rsp_valid"}, rsp_valid, (sb.size() == 0) ? 0 : 1);
    end else begin
      e = sb.pop_front();
      chk({tag, " rsp_rdata"}, rsp_rdata, e.rdata);
      chk({tag, " rsp_err"}, rsp_err, e.err);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, " rsp_valid drop"}, rsp_valid, 0);
      chk({tag, " req_ready back"}, req_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst mem_req_valid", mem_req_valid, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // lb with sign extension from the top byte lane
    do_req("lb", 1'b0, LSU_B, 32'h8000_0003, 32'h0, 32'hFFFF_FF80, 1'b0);
    mem_accept("lb", 32'h8000_0000, 1'b0, 4'b0000, 1'b0, 32'h0);
    mem_resp(32'h80FF_0000);
    take_rsp("lb");

    // sh into the upper half
    do_req("sh", 1'b1, LSU_H, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 1'b0);
    mem_accept("sh", 32'h8000_0000, 1'b1, 4'b1100, 1'b1, 32'hABCD_0000);
    mem_resp(32'hDEAD_BEEF);
    take_rsp("sh");

    // misaligned lw: no bus traffic, error next cycle
    do_req("lw_mis", 1'b0, LSU_W, 32'h8000_0006, 32'h0, 32'h0, 1'b1);
    chk("lw_mis no mem_req", mem_req_valid, 0);
    chk("lw_mis rsp_valid", rsp_valid, 1);
    take_rsp("lw_mis");

    // illegal op
    do_req("ill", 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
    chk("ill no mem_req", mem_req_valid, 0);
    take_rsp("ill");

    // lhu with bus and writeback back-pressure
    do_req("lhu", 1'b0, LSU_HU, 32'h8000_0002, 32'h0, 32'h0000_BEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("lhu stall mem_req_valid", mem_req_valid, 1);
      chk("lhu stall mem_addr", mem_addr, 32'h8000_0000);
      chk("lhu stall req_ready", req_ready, 0);
      @(negedge clk);
    end
    mem_accept("lhu", 32'h8000_0000, 1'b0, 4'b0000, 1'b0, 32'h0);
    mem_resp(32'hBEEF_0000);
    for (int i = 0; i < 2; i++) begin
      chk("lhu hold rsp_valid", rsp_valid, 1);
      chk("lhu hold rsp_rdata", rsp_rdata, 32'h0000_BEEF);
      chk("lhu hold req_ready", req_ready, 0);
      @(negedge clk);
    end
    take_rsp("lhu");

    // more lane patterns
    do_req("sb", 1'b1, LSU_B, 32'h0000_0101, 32'h0000_00AA, 32'h0, 1'b0);
    mem_accept("sb", 32'h0000_0100, 1'b1, 4'b0010, 1'b1, 32'h0000_AA00);
    mem_resp(32'h0);
    take_rsp("sb");
    do_req("sw", 1'b1, LSU_W, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 1'b0);
    mem_accept("sw", 32'h0000_0204, 1'b1, 4'b1111, 1'b1, 32'hCAFE_F00D);
    mem_resp(32'h0);
    take_rsp("sw");
    do_req("lh", 1'b0, LSU_H, 32'h0000_0300, 32'h0, 32'hFFFF_8001, 1'b0);
    mem_accept("lh", 32'h0000_0300, 1'b0, 4'b0000, 1'b0, 32'h0);
    mem_resp(32'h7777_8001);
    take_rsp("lh");
    do_req("lbu", 1'b0, LSU_BU, 32'h0000_0401, 32'h0, 32'h0000_00F0, 1'b0);
    mem_accept("lbu", 32'h0000_0400, 1'b0, 4'b0000, 1'b0, 32'h0);
    mem_resp(32'h0000_F000);
    take_rsp("lbu");

    // timeout after four WAIT cycles
    do_req("to", 1'b0, LSU_W, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    mem_accept("to", 32'h8000_0010, 1'b0, 4'b0000, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to early rsp_valid", rsp_valid, 0);
      @(negedge clk);
    end
    chk("to rsp_valid", rsp_valid, 1);
    take_rsp("to");

    // response in the timeout cycle wins
    do_req("race", 1'b0, LSU_W, 32'h8000_0014, 32'h0, 32'h1122_3344, 1'b0);
    mem_accept("race", 32'h8000_0014, 1'b0, 4'b0000, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    chk("race pre rsp_valid", rsp_valid, 0);
    mem_resp(32'h1122_3344);
    take_rsp("race");

    // reset during WAIT abandons the access
    do_req("rstw", 1'b0, LSU_W, 32'h8000_0020, 32'h0, 32'h0, 1'b0);
    mem_accept("rstw", 32'h8000_0020, 1'b0, 4'b0000, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    chk("rstw req_ready", req_ready, 1);
    chk("rstw mem_req_valid", mem_req_valid, 0);
    chk("rstw mem_addr", mem_addr, 0);
    chk("rstw mem_wen", mem_wen, 0);
    chk("rstw mem_wdata", mem_wdata, 0);
    chk("rstw mem_wstrb", mem_wstrb, 0);
    chk("rstw rsp_valid", rsp_valid, 0);
    chk("rstw rsp_rdata", rsp_rdata, 0);
    chk("rstw rsp_err", rsp_err, 0);
    mem_resp(32'h5555_5555);
    chk("late resp rsp_valid", rsp_valid, 0);
    chk("late resp req_ready", req_ready, 1);

    // recovery after reset
    do_req("post", 1'b0, LSU_BU, 32'h0000_0502, 32'h0, 32'h0000_0034, 1'b0);
    mem_accept("post", 32'h0000_0500, 1'b0, 4'b0000, 1'b0, 32'h0);
    mem_resp(32'h1234_5678);
    take_rsp("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
